wb_uart_tx: RTL and testbench



---
 rtl/uart_tx_pkg.sv | 22 ++
 rtl/wb_uart_tx_if.sv | 28 ++
 rtl/uart_tx_fifo.sv | 50 +++++
 rtl/wb_uart_tx.sv | 195 +++++++++++++++++++
 tb/tb_wb_uart_tx.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_pkg.sv
// Shared definitions for wb_uart_tx: register word offsets, STATUS bit
// positions and the transmitter state encoding.
package uart_tx_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_BAUD   = 2'd2;
  localparam logic [1:0] REG_IRQ    = 2'd3;

  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_LEVEL = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } tx_state_t;

endpackage

// File: rtl/wb_uart_tx_if.sv
// Wishbone B4 classic bus bundle between the CPU data master and wb_uart_tx.
interface wb_uart_tx_if #(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int TW = 3
);
  logic [TW-1:0]   wb_tag;
  logic [AW-1:0]   wb_adr;
  logic            wb_stb;
  logic            wb_cyc;
  logic [DW-1:0]   wb_dwr;
  logic [DW-1:0]   wb_drd;
  logic [DW/8-1:0] wb_sel;
  logic            wb_we;
  logic            wb_lock;
  logic            wb_ack;
  logic            wb_err;

  modport master (
    output wb_tag, wb_adr, wb_stb, wb_cyc, wb_dwr, wb_sel, wb_we, wb_lock,
    input  wb_drd, wb_ack, wb_err
  );

  modport slave (
    input  wb_tag, wb_adr, wb_stb, wb_cyc, wb_dwr, wb_sel, wb_we, wb_lock,
    output wb_drd, wb_ack, wb_err
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO for the UART transmit path; a push is accepted while full
// as long as a pop happens in the same cycle.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign full    = (level == ($clog2(DEPTH)+1)'(DEPTH));
  assign empty   = (level == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/wb_uart_tx.sv
// Wishbone slave console transmitter: FIFO-buffered 8N1 UART output on txd.
// Optional IRQ_EN register and irq output enabled by defining UART_TX_IRQ_EN.
module wb_uart_tx
  import uart_tx_pkg::*;
#(
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int TW        = 3,
  parameter int DEPTH     = 16,
  parameter int DIV_RESET = 868
) (
  input  logic       clk,
  input  logic       rst,
  wb_uart_tx_if.slave bus,
  output logic       txd
`ifdef UART_TX_IRQ_EN
  ,
  output logic       irq
`endif
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          req;
  logic          ack_q;
  logic          err_q;
  logic          err_c;
  logic [DW-1:0] drd_q;
  logic [DW-1:0] rd_val;
  logic [1:0]    reg_sel;
  logic          wr;
  logic          data_wr;
  logic [15:0]   baud;
  logic [15:0]   div_m1;
  logic [15:0]   timer;
  logic          tick;
  tx_state_t     state;
  logic [7:0]    shreg;
  logic [2:0]    bit_cnt;
  logic          busy;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [7:0]    fifo_dout;
  logic [LW-1:0] level;
  logic          unused_ok;
`ifdef UART_TX_IRQ_EN
  logic          irq_en;
`endif

  assign unused_ok = ^{bus.wb_tag[TW-1:0], bus.wb_lock, bus.wb_adr[AW-1:4], bus.wb_adr[1:0],
                       bus.wb_dwr[DW-1:16], bus.wb_sel[DW/8-1:2]};

  // A request is only seen once; the registered termination masks it.
  assign req     = bus.wb_cyc & bus.wb_stb & ~ack_q & ~err_q;
  assign reg_sel = bus.wb_adr[3:2];
  assign wr      = req & bus.wb_we;
  assign data_wr = wr & (reg_sel == REG_DATA) & bus.wb_sel[0];

  assign busy   = (state != S_IDLE);
  assign tick   = (timer == 16'd0);
  assign div_m1 = (baud == 16'd0) ? 16'd0 : baud - 16'd1;
  assign pop    = ~empty & ((state == S_IDLE) | ((state == S_STOP) & tick));

  always_comb begin
    err_c = bus.wb_we & (reg_sel == REG_DATA) & bus.wb_sel[0] & full & ~pop;
`ifndef UART_TX_IRQ_EN
    if (reg_sel == REG_IRQ) err_c = 1'b1;
`endif
  end

  assign push = data_wr & ~err_c;

  always_comb begin
    rd_val = '0;
    case (reg_sel)
      REG_STATUS: begin
        rd_val[STAT_FULL]         = full;
        rd_val[STAT_EMPTY]        = empty;
        rd_val[STAT_BUSY]         = busy;
        rd_val[STAT_LEVEL +: LW]  = level;
      end
      REG_BAUD: rd_val[15:0] = baud;
`ifdef UART_TX_IRQ_EN
      REG_IRQ:  rd_val[0] = irq_en;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      drd_q <= '0;
      baud  <= 16'(DIV_RESET);
`ifdef UART_TX_IRQ_EN
      irq_en <= 1'b0;
      irq    <= 1'b0;
`endif
    end else begin
      ack_q <= req & ~err_c;
      err_q <= req & err_c;
      drd_q <= (req & ~bus.wb_we & ~err_c) ? rd_val : '0;
      if (wr && reg_sel == REG_BAUD) begin
        if (bus.wb_sel[0]) baud[7:0]  <= bus.wb_dwr[7:0];
        if (bus.wb_sel[1]) baud[15:8] <= bus.wb_dwr[15:8];
      end
`ifdef UART_TX_IRQ_EN
      if (wr && reg_sel == REG_IRQ && bus.wb_sel[0]) irq_en <= bus.wb_dwr[0];
      irq <= irq_en & empty & ~busy;
`endif
    end
  end

  assign bus.wb_ack = ack_q;
  assign bus.wb_err = err_q;
  assign bus.wb_drd = drd_q;

  uart_tx_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (bus.wb_dwr[7:0]),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  // The timer is reloaded from BAUD_DIV at every bit boundary, so a new
  // divisor only takes effect on the next bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      txd     <= 1'b1;
      timer   <= 16'd0;
      shreg   <= 8'd0;
      bit_cnt <= 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            shreg <= fifo_dout;
            timer <= div_m1;
            txd   <= 1'b0;
            state <= S_START;
          end
        end
        S_START: begin
          if (tick) begin
            txd     <= shreg[0];
            shreg   <= shreg >> 1;
            timer   <= div_m1;
            bit_cnt <= 3'd0;
            state   <= S_DATA;
          end else begin
            timer <= timer - 16'd1;
          end
        end
        S_DATA: begin
          if (tick) begin
            timer <= div_m1;
            if (bit_cnt == 3'd7) begin
              txd   <= 1'b1;
              state <= S_STOP;
            end else begin
              txd     <= shreg[0];
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            timer <= timer - 16'd1;
          end
        end
        S_STOP: begin
          if (tick) begin
            if (pop) begin
              shreg <= fifo_dout;
              timer <= div_m1;
              txd   <= 1'b0;
              state <= S_START;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            timer <= timer - 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_uart_tx.sv
// Self-checking bench for wb_uart_tx: bus scoreboard plus a UART line monitor
// that checks every cycle of each frame against the expected 8N1 waveform.
module tb_wb_uart_tx;
  localparam int DW = 32, AW = 32, TW = 3, DEPTH = 16, DIV_RESET = 868;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic txd;
`ifdef UART_TX_IRQ_EN
  logic irq;
`endif

  wb_uart_tx_if #(.DW(DW), .AW(AW), .TW(TW)) bus ();

  wb_uart_tx #(.DW(DW), .AW(AW), .TW(TW), .DEPTH(DEPTH), .DIV_RESET(DIV_RESET)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .txd (txd)
`ifdef UART_TX_IRQ_EN
    ,
    .irq (irq)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc_cnt = 0;
  int last_issue = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  typedef struct {
    logic        err;
    logic        chk;
    logic [31:0] rd;
    int          cyc;
  } bus_exp_t;

  bus_exp_t    bq[$];
  logic [7:0]  txq[$];
  logic [15:0] model_baud = 16'(DIV_RESET);

  int   in_frame = 0;
  int   fcnt, fdiv, ferr;
  logic [9:0] fbits;
  int   fall_cycle = -1;
  logic prev_txd = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc_cnt);
    end
  endtask

  function automatic logic [31:0] stat(input bit f, input bit e, input bit b, input int lvl);
    return (32'(lvl) << 8) | (32'(b) << 2) | (32'(e) << 1) | 32'(f);
  endfunction

  // Bus monitor: every termination must match the oldest outstanding request.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (bus.wb_ack || bus.wb_err) begin
        if (bq.size() == 0) begin
          check("spurious_term", {30'b0, bus.wb_err, bus.wb_ack}, 32'd0);
        end else begin
          bus_exp_t e;
          e = bq.pop_front();
          check("term_kind", {30'b0, bus.wb_err, bus.wb_ack}, {30'b0, e.err, ~e.err});
          check("term_cycle", cyc_cnt, e.cyc);
          if (e.chk) check("rdata", bus.wb_drd, e.rd);
        end
      end else begin
        check("idle_drd", bus.wb_drd, 32'd0);
      end
    end
  end

  // Line monitor: expected frame = start 0, 8 data bits LSB first, stop 1,
  // each held for max(BAUD_DIV,1) cycles.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      in_frame = 0;
      txq.delete();
    end else if (in_frame != 0) begin
      if (txd !== fbits[fcnt / fdiv]) ferr++;
      fcnt++;
      if (fcnt == 10 * fdiv) begin
        check("frame_bad_cycles", ferr, 0);
        in_frame = 0;
      end
    end else if (txd === 1'b0) begin
      if (txq.size() != 0) begin
        logic [7:0] b;
        b = txq.pop_front();
        fbits = {1'b1, b, 1'b0};
        fdiv = (model_baud == 16'd0) ? 1 : int'(model_baud);
        fcnt = 1;
        ferr = 0;
        fall_cycle = cyc_cnt;
        in_frame = 1;
        if (fdiv == 1 && fcnt == 10) in_frame = 0;
      end else if (prev_txd === 1'b1) begin
        check("spurious_start_txd", {31'b0, txd}, 32'd1);
      end
    end
    prev_txd = txd;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d miscompares=%0d", vectors, miscompares);
    $fatal(1, "watchdog");
  end

  task automatic xfer(input logic we, input logic [3:0] off, input logic [31:0] dat,
                      input logic [3:0] sel, input logic exp_err, input logic chk,
                      input logic [31:0] exp_rd);
    logic [31:0] a;
    bus_exp_t e;
    @(posedge clk); #1;
    a = $urandom();
    a[3:2] = off[3:2];
    bus.wb_adr  = a;
    bus.wb_tag  = 3'($urandom());
    bus.wb_lock = 1'($urandom());
    bus.wb_we   = we;
    bus.wb_dwr  = dat;
    bus.wb_sel  = sel;
    bus.wb_cyc  = 1'b1;
    bus.wb_stb  = 1'b1;
    last_issue  = cyc_cnt;
    e = '{err: exp_err, chk: chk, rd: exp_rd, cyc: cyc_cnt + 1};
    bq.push_back(e);
    @(posedge clk); #1;
    bus.wb_cyc = 1'b0;
    bus.wb_stb = 1'b0;
    bus.wb_we  = 1'b0;
  endtask

  task automatic rd(input logic [3:0] off, input logic [31:0] exp);
    xfer(1'b0, off, $urandom(), 4'($urandom()), 1'b0, 1'b1, exp);
  endtask

  task automatic send(input logic [7:0] b, input logic exp_err);
    logic [31:0] d;
    logic [3:0] s;
    d = $urandom();
    d[7:0] = b;
    s = 4'($urandom()) | 4'b0001;
    if (!exp_err) txq.push_back(b);
    xfer(1'b1, 4'h0, d, s, exp_err, 1'b0, 32'd0);
  endtask

  task automatic wr_baud(input logic [31:0] d, input logic [3:0] s);
    if (s[0]) model_baud[7:0]  = d[7:0];
    if (s[1]) model_baud[15:8] = d[15:8];
    xfer(1'b1, 4'h8, d, s, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic wait_issue(input int t);
    while (cyc_cnt < t - 1) begin @(posedge clk); #1; end
  endtask

  task automatic sample_at(input int t);
    do @(negedge clk); while (cyc_cnt < t);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((txq.size() != 0 || in_frame != 0) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    vectors++;
    if (n >= budget) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d bytes still queued after %0d cycles", txq.size(), budget);
      txq.delete();
    end
    repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin
    int f;
    int r;
    logic [15:0] bd;
    bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0; bus.wb_we = 1'b0; bus.wb_adr = '0;
    bus.wb_dwr = '0; bus.wb_sel = '0; bus.wb_tag = '0; bus.wb_lock = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_txd", {31'b0, txd}, 32'd1);
    check("rst_ack_err", {30'b0, bus.wb_ack, bus.wb_err}, 32'd0);
    check("rst_drd", bus.wb_drd, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    rd(4'h4, stat(0, 1, 0, 0));
    rd(4'h8, 32'(DIV_RESET));
    rd(4'h0, 32'd0);
    wr_baud(32'h0000_1234, 4'b0001);
    rd(4'h8, 32'h0000_0334);

    // Request withdrawn before any clock edge sees it: no termination, no push.
    @(posedge clk); #1;
    bus.wb_adr = 32'h0; bus.wb_we = 1'b1; bus.wb_sel = 4'hF; bus.wb_dwr = 32'hA5;
    bus.wb_cyc = 1'b1; bus.wb_stb = 1'b1;
    #3;
    bus.wb_cyc = 1'b0; bus.wb_stb = 1'b0; bus.wb_we = 1'b0;
    rd(4'h4, stat(0, 1, 0, 0));

    wr_baud(32'h0000_0004, 4'b0011);
`ifdef UART_TX_IRQ_EN
    xfer(1'b1, 4'hC, 32'h1, 4'b0001, 1'b0, 1'b0, 32'd0);
    rd(4'hC, 32'd1);
`else
    xfer(1'b0, 4'hC, 32'h0, 4'hF, 1'b1, 1'b0, 32'd0);
    xfer(1'b1, 4'hC, 32'h1, 4'hF, 1'b1, 1'b0, 32'd0);
`endif

    send(8'h55, 1'b0);
    f = last_issue + 2;
`ifdef UART_TX_IRQ_EN
    sample_at(f + 20);
    check("irq_busy", {31'b0, irq}, 32'd0);
`endif
    wait_issue(f + 39);
    rd(4'h4, stat(0, 1, 1, 0));
`ifdef UART_TX_IRQ_EN
    sample_at(f + 40);
    check("irq_at_idle", {31'b0, irq}, 32'd0);
    sample_at(f + 41);
    check("irq_after_idle", {31'b0, irq}, 32'd1);
`endif
    check("fall_latency", fall_cycle, f);
    drain(200);

    send(8'($urandom()), 1'b0);
    f = last_issue + 2;
    wait_issue(f + 40);
    rd(4'h4, stat(0, 1, 0, 0));
    drain(200);

    for (int round = 0; round < 6; round++) begin
      bd = (round == 0) ? 16'd0 : (round == 1) ? 16'd1 : 16'($urandom_range(2, 6));
      wr_baud({16'($urandom()), bd}, 4'b0011 | 4'($urandom() & 32'hC));
      rd(4'h8, {16'd0, bd});
      for (int k = 0; k < int'($urandom_range(1, 8)); k++) begin
        send(8'($urandom()), 1'b0);
        r = $urandom_range(0, 5);
        case (r)
          0: rd(4'h0, 32'd0);
          1: xfer(1'b1, 4'h0, $urandom(), 4'($urandom()) & 4'b1110, 1'b0, 1'b0, 32'd0);
`ifdef UART_TX_IRQ_EN
          2: rd(4'hC, 32'd1);
`else
          2: xfer(1'b0, 4'hC, 32'h0, 4'hF, 1'b1, 1'b0, 32'd0);
`endif
          3: xfer(1'b1, 4'h4, $urandom(), 4'hF, 1'b0, 1'b0, 32'd0);
          default: ;
        endcase
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      end
      drain(1000);
      rd(4'h4, stat(0, 1, 0, 0));
    end

    // Slow divisor so nothing drains: the first byte moves into the shifter
    // one cycle after its push, so DEPTH more bytes fill the FIFO and the
    // next write is refused.
    wr_baud(32'd1000, 4'b0011);
    send(8'h00, 1'b0);
    for (int i = 1; i <= DEPTH + 1; i++) send(8'($urandom()), (i == DEPTH + 1));
    rd(4'h4, stat(1, 0, 1, DEPTH));

    while (cyc_cnt < fall_cycle + 1500) begin @(posedge clk); #1; end
    check("txd_mid_data", {31'b0, txd}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("txd_async_rst", {31'b0, txd}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_baud = 16'(DIV_RESET);
    rd(4'h4, stat(0, 1, 0, 0));
    rd(4'h8, 32'(DIV_RESET));
    repeat (5) begin @(posedge clk); #1; end

    check("bus_queue_empty", bq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
